// File: rtl/serial_receiver_param.sv
// Oversampled UART-style receiver with majority voting, false-start rejection,
// break handling and a valid/ready holding register with error reporting.
module serial_receiver_param #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_parity_error,
  output logic                 o_frame_error,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam int unsigned M  = OVERSAMPLE / 2;

  localparam logic [TW-1:0] POS_A     = TW'(M - 1);
  localparam logic [TW-1:0] POS_B     = TW'(M);
  localparam logic [TW-1:0] POS_V     = TW'(M + 1);
  localparam logic [TW-1:0] POS_END   = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK
  } state_t;

  state_t                 state;
  logic                   rx_meta;
  logic                   rx_s;
  logic [TW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic                   smp_a;
  logic                   smp_b;
  logic [DATA_BITS-1:0]   shreg;
  logic                   perr;
  logic                   ferr;

  logic at_vote;
  logic at_end;
  logic vote;
  logic done;
  logic done_ferr;

  assign at_vote   = i_tick && (tick_cnt == POS_V);
  assign at_end    = i_tick && (tick_cnt == POS_END);
  assign vote      = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
  assign done      = at_vote && (state == S_STOP) && (bit_cnt == LAST_STOP);
  assign done_ferr = ferr | ~vote;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame sequencer, advanced only on oversample ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      smp_a    <= 1'b1;
      smp_b    <= 1'b1;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else if (i_tick) begin
      if (state == S_IDLE || state == S_BREAK)
        tick_cnt <= '0;
      else
        tick_cnt <= (tick_cnt == POS_END) ? '0 : tick_cnt + TW'(1);
      if (tick_cnt == POS_A) smp_a <= rx_s;
      if (tick_cnt == POS_B) smp_b <= rx_s;

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state    <= S_START;
            tick_cnt <= TW'(1);
            perr     <= 1'b0;
            ferr     <= 1'b0;
          end
        end
        S_START: begin
          if (at_vote && vote) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
          end else if (at_end) begin
            state   <= S_DATA;
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (at_vote) shreg <= {vote, shreg[DATA_BITS-1:1]};
          if (at_end) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        S_PAR: begin
          if (at_vote) perr <= (^{shreg, vote}) ^ ODD;
          if (at_end) begin
            state   <= S_STOP;
            bit_cnt <= '0;
          end
        end
        S_STOP: begin
          // Last stop bit completes at its vote so the next start edge is not missed
          if (at_vote) begin
            if (!vote) ferr <= 1'b1;
            if (bit_cnt == LAST_STOP) begin
              state    <= done_ferr ? S_BREAK : S_IDLE;
              tick_cnt <= '0;
              bit_cnt  <= '0;
            end
          end else if (at_end) begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        S_BREAK: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Holding register: a completing frame wins over a pending handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      o_data         <= '0;
      o_valid        <= 1'b0;
      o_parity_error <= 1'b0;
      o_frame_error  <= 1'b0;
      o_overrun      <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      o_busy    <= (state != S_IDLE);
      if (done) begin
        if (!o_valid || i_ready) begin
          o_data         <= shreg;
          o_parity_error <= perr;
          o_frame_error  <= done_ferr;
          o_valid        <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid        <= 1'b0;
        o_parity_error <= 1'b0;
        o_frame_error  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_receiver_param.sv
// Bench for serial_receiver_param: 8N1/x16 and 7E2/x8 instances driven from a
// frame-level model, with a per-cycle compare against an expected-frame queue.
module tb_serial_receiver_param;

  localparam int unsigned OS_A = 16, DB_A = 8, PAR_A = 0, SB_A = 1;
  localparam int unsigned OS_B = 8,  DB_B = 7, PAR_B = 2, SB_B = 2;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       drop;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick  [2];
  logic rx    [2];
  logic ready [2];
  bit   always_tick [2];

  logic [DB_A-1:0] data_a;
  logic [DB_B-1:0] data_b;
  logic valid_a, perr_a, ferr_a, ovr_a, busy_a;
  logic valid_b, perr_b, ferr_b, ovr_b, busy_b;

  int   cyc = 0;
  int   t_start [2];
  int   errors = 0;
  int   checks = 0;
  int   ovr_count [2];
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t held [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_receiver_param #(.OVERSAMPLE(OS_A), .DATA_BITS(DB_A), .PARITY(PAR_A), .STOP_BITS(SB_A)) dut_a (
    .clk(clk), .rst(rst), .i_tick(tick[0]), .i_rx(rx[0]),
    .o_data(data_a), .o_valid(valid_a), .i_ready(ready[0]),
    .o_parity_error(perr_a), .o_frame_error(ferr_a), .o_overrun(ovr_a), .o_busy(busy_a));

  serial_receiver_param #(.OVERSAMPLE(OS_B), .DATA_BITS(DB_B), .PARITY(PAR_B), .STOP_BITS(SB_B)) dut_b (
    .clk(clk), .rst(rst), .i_tick(tick[1]), .i_rx(rx[1]),
    .o_data(data_b), .o_valid(valid_b), .i_ready(ready[1]),
    .o_parity_error(perr_b), .o_frame_error(ferr_b), .o_overrun(ovr_b), .o_busy(busy_b));

  task automatic check(input string name, input int sel, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at cycle %0d", name, sel, act, exp, cyc);
    end
  endtask

  function automatic int qsize(input int sel);
    return (sel == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(input int sel, input exp_t e);
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic qpop(input int sel, output exp_t e);
    if (sel == 0) e = q0.pop_front(); else e = q1.pop_front();
  endtask

  // Per-cycle compare against the expected-frame queue and the held frame
  logic pv [2];
  logic pr [2];
  logic rst_prev = 1'b1;
  always @(negedge clk) begin
    logic [8:0] od;
    logic ov, ope, ofe, oov, ob;
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      od  = (d == 0) ? 9'(data_a) : 9'(data_b);
      ov  = (d == 0) ? valid_a : valid_b;
      ope = (d == 0) ? perr_a  : perr_b;
      ofe = (d == 0) ? ferr_a  : ferr_b;
      oov = (d == 0) ? ovr_a   : ovr_b;
      ob  = (d == 0) ? busy_a  : busy_b;
      if (rst_prev) begin
        check("reset_outputs", d, 32'({od, ov, ope, ofe, oov, ob}), 32'd0);
        held[d] = '{9'd0, 1'b0, 1'b0, 1'b0};
      end else begin
        if (oov) begin
          ovr_count[d]++;
          check("overrun_pending", d, 32'(qsize(d) > 0), 32'd1);
          if (qsize(d) > 0) begin
            qpop(d, e);
            check("overrun_was_drop", d, 32'(e.drop), 32'd1);
          end
        end
        if (ov && (!pv[d] || pr[d])) begin
          check("frame_pending", d, 32'(qsize(d) > 0), 32'd1);
          if (qsize(d) > 0) begin
            qpop(d, e);
            held[d] = e;
            check("frame_not_drop", d, 32'(e.drop), 32'd0);
            check("data", d, 32'(od), 32'(e.data));
            check("parity_error", d, 32'(ope), 32'(e.perr));
            check("frame_error", d, 32'(ofe), 32'(e.ferr));
          end
        end else if (ov) begin
          check("held_stable", d, 32'({od, ope, ofe}), 32'({held[d].data, held[d].perr, held[d].ferr}));
        end else if (pv[d] && !pr[d]) begin
          check("valid_kept_without_ready", d, 32'(ov), 32'd1);
        end
      end
      pv[d] = ov;
      pr[d] = ready[d];
    end
    rst_prev = rst;
  end

  // Hold the current line level for exactly one oversample tick
  task automatic tick_once(input int sel);
    logic t;
    do begin
      t = always_tick[sel] ? 1'b1 : 1'($urandom_range(0, 2) == 0);
      tick[sel] = t;
      @(posedge clk); #1;
    end while (!t);
    tick[sel] = 1'b0;
  endtask

  task automatic idle(input int sel, input int n);
    rx[sel] = 1'b1;
    repeat (n) tick_once(sel);
  endtask

  task automatic send_line(input int sel, input logic bits[$], input int gbit, input int gtick, input int max_ticks);
    int os;
    int n;
    os = (sel == 0) ? OS_A : OS_B;
    n = 0;
    t_start[sel] = cyc;
    foreach (bits[b]) begin
      for (int t = 0; t < os; t++) begin
        if (max_ticks >= 0 && n >= max_ticks) return;
        rx[sel] = bits[b] ^ 1'(b == gbit && t == gtick);
        tick_once(sel);
        n++;
      end
    end
    rx[sel] = 1'b1;
  endtask

  // Builds the line waveform and the expected outcome from the frame fields
  task automatic send_frame(input int sel, input logic [8:0] d, input bit bad_par, input logic [1:0] stops,
                            input bit drop, input int gbit, input int gtick, input int max_ticks);
    int db, pm, sb, os, ones;
    logic pbit;
    logic bits[$];
    exp_t e;
    db = (sel == 0) ? DB_A : DB_B;
    pm = (sel == 0) ? PAR_A : PAR_B;
    sb = (sel == 0) ? SB_A : SB_B;
    os = (sel == 0) ? OS_A : OS_B;
    e.data = '0;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < db; i++) begin
      bits.push_back(d[i]);
      e.data[i] = d[i];
      ones += int'(d[i]);
    end
    pbit = (pm == 1) ? 1'((ones % 2) == 0) : 1'((ones % 2) == 1);
    pbit = pbit ^ bad_par;
    if (pm != 0) bits.push_back(pbit);
    e.perr = 1'(pm != 0 && ((ones + int'(pbit)) % 2) != ((pm == 1) ? 1 : 0));
    e.ferr = 1'b0;
    for (int i = 0; i < sb; i++) begin
      bits.push_back(stops[i]);
      if (!stops[i]) e.ferr = 1'b1;
    end
    e.drop = drop;
    if (max_ticks < 0) qpush(sel, e);
    send_line(sel, bits, gbit, gtick, max_ticks);
    if (max_ticks < 0) idle(sel, 2 * os);
  endtask

  task automatic wait_drain(input int sel);
    int n;
    n = 0;
    while (qsize(sel) != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("queue_drained", sel, 32'(qsize(sel)), 32'd0);
  endtask

  task automatic release_frame(input int sel);
    ready[sel] = 1'b1;
    @(posedge clk); #1;
    ready[sel] = 1'b0;
  endtask

  initial begin
    int ov_base;
    bit busy_seen;
    logic zeros[$];
    for (int i = 0; i < 2; i++) begin
      tick[i] = 1'b0;
      rx[i] = 1'b1;
      ready[i] = 1'b1;
      always_tick[i] = 1'b1;
      ovr_count[i] = 0;
      pv[i] = 1'b0;
      pr[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", 0, 32'(valid_a), 32'd0);
    check("rst_busy", 0, 32'(busy_a), 32'd0);
    check("rst_data", 1, 32'(data_b), 32'd0);
    idle(0, 4);

    // 8N1 basic with latency and single-cycle valid
    fork
      send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b0, -1, 0, -1);
      begin : mon_a5
        int n;
        n = 0;
        while (!valid_a && n < 400) begin
          @(negedge clk);
          n++;
        end
        check("a5_latency", 0, 32'(cyc - t_start[0]), 32'd156);
        check("a5_data", 0, 32'(data_a), 32'h0A5);
        check("a5_flags", 0, 32'({perr_a, ferr_a}), 32'd0);
        @(negedge clk);
        check("a5_valid_one_clk", 0, 32'(valid_a), 32'd0);
      end
    join
    wait_drain(0);

    // Short low pulse is a false start; then a mid-bit glitch is voted out
    rx[0] = 1'b0;
    repeat (4) tick_once(0);
    rx[0] = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 3 * OS_A; i++) begin
      tick_once(0);
      if (busy_a) busy_seen = 1'b1;
    end
    check("glitch_busy_seen", 0, 32'(busy_seen), 32'd1);
    check("glitch_busy_clear", 0, 32'(busy_a), 32'd0);
    check("glitch_no_valid", 0, 32'(valid_a), 32'd0);
    send_frame(0, 9'h03C, 1'b0, 2'b11, 1'b0, 3, OS_A / 2, -1);
    wait_drain(0);

    // Overrun: second frame dropped while the first is still held
    ready[0] = 1'b0;
    ov_base = ovr_count[0];
    send_frame(0, 9'h011, 1'b0, 2'b11, 1'b0, -1, 0, -1);
    send_frame(0, 9'h022, 1'b0, 2'b11, 1'b1, -1, 0, -1);
    wait_drain(0);
    check("ovr_data_kept", 0, 32'(data_a), 32'h011);
    check("ovr_valid", 0, 32'(valid_a), 32'd1);
    check("ovr_pulses", 0, 32'(ovr_count[0] - ov_base), 32'd1);
    ready[0] = 1'b1;
    @(posedge clk); #1;
    check("ovr_ready_clears", 0, 32'(valid_a), 32'd0);

    // Completion coincident with handshake replaces the held frame
    ready[0] = 1'b0;
    send_frame(0, 9'h011, 1'b0, 2'b11, 1'b0, -1, 0, -1);
    ov_base = ovr_count[0];
    fork
      send_frame(0, 9'h022, 1'b0, 2'b11, 1'b0, -1, 0, -1);
      begin : pulse
        int n;
        n = 0;
        @(posedge clk); #1;
        while (cyc < t_start[0] + 155 && n < 1000) begin
          @(posedge clk); #1;
          n++;
        end
        ready[0] = 1'b1;
        @(posedge clk); #1;
        ready[0] = 1'b0;
      end
    join
    wait_drain(0);
    check("b2b_data", 0, 32'(data_a), 32'h022);
    check("b2b_valid", 0, 32'(valid_a), 32'd1);
    check("b2b_no_overrun", 0, 32'(ovr_count[0] - ov_base), 32'd0);

    // Reset during data bit 4 with a frame held
    send_frame(0, 9'h077, 1'b0, 2'b11, 1'b1, -1, 0, 5 * OS_A + OS_A / 2);
    rst = 1'b1;
    rx[0] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_valid", 0, 32'(valid_a), 32'd0);
    check("midrst_data", 0, 32'(data_a), 32'd0);
    check("midrst_busy", 0, 32'(busy_a), 32'd0);
    ready[0] = 1'b1;
    idle(0, 2 * OS_A);
    send_frame(0, 9'h05A, 1'b0, 2'b11, 1'b0, -1, 0, -1);
    wait_drain(0);

    // Line held low for 30 bits: one errored frame, then recovery
    ready[0] = 1'b0;
    qpush(0, '{9'h000, 1'b0, 1'b1, 1'b0});
    for (int i = 0; i < 30; i++) zeros.push_back(1'b0);
    send_line(0, zeros, -1, 0, -1);
    idle(0, 2 * OS_A);
    wait_drain(0);
    check("break_data", 0, 32'(data_a), 32'h000);
    check("break_ferr", 0, 32'(ferr_a), 32'd1);
    release_frame(0);
    send_frame(0, 9'h081, 1'b0, 2'b11, 1'b0, -1, 0, -1);
    wait_drain(0);
    check("after_break_data", 0, 32'(data_a), 32'h081);
    check("after_break_ferr", 0, 32'(ferr_a), 32'd0);
    release_frame(0);

    // 7E2 parity and framing
    ready[1] = 1'b0;
    idle(1, 2);
    send_frame(1, 9'h053, 1'b0, 2'b11, 1'b0, -1, 0, -1);
    wait_drain(1);
    check("e7_good_data", 1, 32'(data_b), 32'h053);
    check("e7_good_perr", 1, 32'(perr_b), 32'd0);
    release_frame(1);
    send_frame(1, 9'h053, 1'b1, 2'b11, 1'b0, -1, 0, -1);
    wait_drain(1);
    check("e7_bad_data", 1, 32'(data_b), 32'h053);
    check("e7_bad_perr", 1, 32'(perr_b), 32'd1);
    release_frame(1);
    send_frame(1, 9'h02A, 1'b0, 2'b01, 1'b0, -1, 0, -1);
    wait_drain(1);
    check("stop2_low_data", 1, 32'(data_b), 32'h02A);
    check("stop2_low_ferr", 1, 32'(ferr_b), 32'd1);
    release_frame(1);
    send_frame(1, 9'h015, 1'b0, 2'b11, 1'b0, -1, 0, -1);
    wait_drain(1);
    check("clean_flags", 1, 32'({perr_b, ferr_b}), 32'd0);
    release_frame(1);

    // Randomised frames with irregular ticks
    for (int s = 0; s < 2; s++) begin
      ready[s] = 1'b1;
      for (int k = 0; k < 25; k++) begin
        logic [1:0] st;
        always_tick[s] = 1'($urandom_range(0, 1));
        st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
        send_frame(s, 9'($urandom), 1'(s == 1 && $urandom_range(0, 3) == 0), st, 1'b0, -1, 0, -1);
        wait_drain(s);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
